// File: rtl/not_not_judge.sv
// -----------------------------------------------------------------------------
// not_not_judge
//
// Judges one round of the "not not" reaction game. A prompt arrives as a
// one-cycle round_start pulse carrying a mask of acceptable switches. The
// judge waits for every switch to be released. It then opens an answer window
// and scores the first switch press, or scores a timeout if no press arrives.
//
// Parameters
//   TICKS_PER_ROUND  answer window in CLOCK_50 cycles (16 .. 2^26-1)
//   START_LIVES      lives loaded at reset (1 .. 3)
//
// Optional feature
//   NOT_NOT_SPEEDUP_EN  when defined, the window shrinks by TICKS_PER_ROUND/16
//                       for every point scored. It never goes below
//                       TICKS_PER_ROUND/4. The window is sampled when the
//                       round arms.
//
// Ports
//   CLOCK_50     in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   round_start  in   one-cycle prompt pulse
//   expected     in   [3:0] acceptable-switch mask, sampled on round_start
//   player_sw    in   [3:0] raw asynchronous player switches
//   score        out  [6:0] correct answers, saturates at 99
//   lives        out  [1:0] remaining lives
//   round_done   out  one-cycle pulse while a round is being judged
//   result_ok    out  verdict of the last judged round
//   busy         out  high while a round is in progress (ARM/WAIT/JUDGE)
//   game_over    out  high once all lives are gone; only reset leaves it
// -----------------------------------------------------------------------------
module not_not_judge #(
    parameter int TICKS_PER_ROUND = 50000000,
    parameter int START_LIVES     = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       round_start,
    input  logic [3:0] expected,
    input  logic [3:0] player_sw,
    output logic [6:0] score,
    output logic [1:0] lives,
    output logic       round_done,
    output logic       result_ok,
    output logic       busy,
    output logic       game_over
);

    // The timer only ever counts up to window-1 <= TICKS_PER_ROUND-1.
    localparam int TW = $clog2(TICKS_PER_ROUND);
    localparam logic [TW-1:0] FULL_LIMIT_M1 = TW'(TICKS_PER_ROUND - 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT, JUDGE, OVER} state_t;

    state_t        state;
    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic [3:0]    sw_prev;
    logic [3:0]    mask_q;
    logic [TW-1:0] timer;
    logic [TW-1:0] limit_m1;

    logic [3:0]    pressed;
    logic          any_press;
    logic          single_press;
    logic          timeout;
    logic          verdict;

`ifdef NOT_NOT_SPEEDUP_EN
    // The product score*step can exceed the timer width, so the window is
    // worked out in a wide word and clamped before it is narrowed.
    localparam logic [33:0] T_FULL  = 34'(TICKS_PER_ROUND);
    localparam logic [33:0] T_STEP  = 34'(TICKS_PER_ROUND >> 4);
    localparam logic [33:0] T_FLOOR = 34'(TICKS_PER_ROUND >> 2);

    logic [33:0] cut;
    logic [33:0] speed_limit;

    always_comb begin
        cut         = 34'(score) * T_STEP;
        speed_limit = T_FULL - cut;
        if (cut >= (T_FULL - T_FLOOR)) begin
            speed_limit = T_FLOOR;
        end
    end
`else
    assign limit_m1 = FULL_LIMIT_M1;
`endif

    // Two flops synchronise the switches. A third copy holds the previous
    // synchronised value, so a press is seen as a 0->1 edge of a switch.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= 4'd0;
            sw_sync <= 4'd0;
            sw_prev <= 4'd0;
        end else begin
            sw_meta <= player_sw;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
        end
    end

    // A press outranks a timeout that lands in the same cycle. Two or more
    // bits rising together count as a wrong answer.
    always_comb begin
        pressed      = sw_sync & ~sw_prev;
        any_press    = |pressed;
        single_press = any_press && ((pressed & (pressed - 4'd1)) == 4'd0);
        timeout      = (timer == limit_m1);
        verdict      = any_press ? (single_press && (|(pressed & mask_q)))
                                 : (mask_q == 4'd0);
    end

    // Round FSM. The visible outputs change on the edge that enters each
    // state, so JUDGE is exactly the single cycle in which round_done is high.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            score      <= 7'd0;
            lives      <= 2'(START_LIVES);
            round_done <= 1'b0;
            result_ok  <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            timer      <= '0;
            mask_q     <= 4'd0;
`ifdef NOT_NOT_SPEEDUP_EN
            limit_m1   <= FULL_LIMIT_M1;
`endif
        end else begin
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (round_start) begin
                        mask_q <= expected;
                        busy   <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    // A switch already held down does not count as an answer.
                    // Wait until every switch is released.
                    if (sw_sync == 4'd0) begin
                        timer <= '0;
`ifdef NOT_NOT_SPEEDUP_EN
                        limit_m1 <= TW'(speed_limit - 34'd1);
`endif
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (any_press || timeout) begin
                        round_done <= 1'b1;
                        result_ok  <= verdict;
                        if (verdict) begin
                            if (score != 7'd99) begin
                                score <= score + 7'd1;
                            end
                        end else begin
                            lives <= lives - 2'd1;
                        end
                        state <= JUDGE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                JUDGE: begin
                    busy <= 1'b0;
                    if (lives == 2'd0) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_not_not_judge.sv
// -----------------------------------------------------------------------------
// tb_not_not_judge
//
// Directed bench for not_not_judge with TICKS_PER_ROUND=16 and START_LIVES=3.
// Each stimulus task plays a whole round. As it does, it moves a small game
// model: score, lives, verdict and round timing, all taken from the game
// rules. A negedge process compares every output with that model on every
// cycle. Literal checks at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_not_not_judge;

    localparam int TICKS  = 16;
    localparam int LIVES0 = 3;
`ifdef NOT_NOT_SPEEDUP_EN
    localparam int WIN_AT_8 = 8;
`else
    localparam int WIN_AT_8 = 16;
`endif

    logic       CLOCK_50    = 1'b0;
    logic       resetn      = 1'b0;
    logic       round_start = 1'b0;
    logic [3:0] expected    = 4'd0;
    logic [3:0] player_sw   = 4'd0;
    logic [6:0] score;
    logic [1:0] lives;
    logic       round_done;
    logic       result_ok;
    logic       busy;
    logic       game_over;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   check_en    = 1'b0;

    int   exp_score;
    int   exp_lives;
    bit   exp_round_done;
    bit   exp_result_ok;
    bit   exp_busy;
    bit   exp_game_over;
    logic [3:0] sw_level = 4'd0;

    not_not_judge #(
        .TICKS_PER_ROUND(TICKS),
        .START_LIVES    (LIVES0)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .round_start(round_start),
        .expected   (expected),
        .player_sw  (player_sw),
        .score      (score),
        .lives      (lives),
        .round_done (round_done),
        .result_ok  (result_ok),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (check_en) begin
            checkOutput("score",      int'(score),      exp_score);
            checkOutput("lives",      int'(lives),      exp_lives);
            checkOutput("round_done", int'(round_done), int'(exp_round_done));
            checkOutput("result_ok",  int'(result_ok),  int'(exp_result_ok));
            checkOutput("busy",       int'(busy),       int'(exp_busy));
            checkOutput("game_over",  int'(game_over),  int'(exp_game_over));
        end
    end

    // Drive one cycle of inputs, then step just past the next rising edge.
    task automatic applyStimulus(input bit rs, input logic [3:0] mask, input logic [3:0] sw);
        round_start = rs;
        expected    = mask;
        player_sw   = sw;
        sw_level    = sw;
        @(posedge CLOCK_50);
        #1;
        round_start = 1'b0;
        expected    = 4'hF;
    endtask

    task automatic tick();
        applyStimulus(1'b0, 4'hF, sw_level);
    endtask

    // ---------------- game model ----------------
    function automatic int window(input int s);
        int w;
        w = TICKS;
`ifdef NOT_NOT_SPEEDUP_EN
        w = TICKS - s * (TICKS / 16);
        if (w < TICKS / 4) w = TICKS / 4;
`endif
        return w;
    endfunction

    function automatic bit press_verdict(input logic [3:0] mask, input logic [3:0] p);
        return ($countones(p) == 1) && ((p & mask) != 4'd0);
    endfunction

    task automatic model_reset();
        exp_score      = 0;
        exp_lives      = LIVES0;
        exp_round_done = 1'b0;
        exp_result_ok  = 1'b0;
        exp_busy       = 1'b0;
        exp_game_over  = 1'b0;
    endtask

    task automatic model_judge(input bit ok);
        exp_round_done = 1'b1;
        exp_result_ok  = ok;
        if (ok) exp_score = (exp_score < 99) ? exp_score + 1 : 99;
        else    exp_lives = exp_lives - 1;
    endtask

    task automatic model_end_judge();
        exp_round_done = 1'b0;
        exp_busy       = 1'b0;
        if (exp_lives == 0) exp_game_over = 1'b1;
    endtask

    // ---------------- round drivers ----------------
    task automatic do_reset(input int cycles);
        resetn      = 1'b0;
        round_start = 1'b0;
        player_sw   = 4'd0;
        sw_level    = 4'd0;
        model_reset();
        repeat (cycles) tick();
        resetn = 1'b1;
        tick();
    endtask

    // Press `pattern` d cycles after the answer window opens. The switches
    // are released and given time to resynchronise before returning.
    task automatic play_press(input logic [3:0] mask, input logic [3:0] pattern, input int d);
        applyStimulus(1'b1, mask, 4'd0);
        exp_busy = 1'b1;
        tick();
        repeat (d) tick();
        applyStimulus(1'b0, 4'hF, pattern);
        tick();
        tick();
        model_judge(press_verdict(mask, pattern));
        tick();
        model_end_judge();
        applyStimulus(1'b0, 4'hF, 4'd0);
        tick();
        tick();
    endtask

    task automatic play_timeout(input logic [3:0] mask);
        int w;
        w = window(exp_score);
        applyStimulus(1'b1, mask, 4'd0);
        exp_busy = 1'b1;
        tick();
        repeat (w) tick();
        model_judge(mask == 4'd0);
        tick();
        model_end_judge();
    endtask

    initial begin
        model_reset();
        check_en = 1'b1;
        do_reset(3);
        checkOutput("lit_reset_lives", int'(lives), 3);

        // Correct single press.
        play_press(4'b0100, 4'b0100, 0);
        checkOutput("lit_ok_score",  int'(score),     1);
        checkOutput("lit_ok_lives",  int'(lives),     3);
        checkOutput("lit_ok_result", int'(result_ok), 1);

        // Two bits rising together is wrong, even though both are in the mask.
        play_press(4'b0011, 4'b0011, 2);
        checkOutput("lit_dbl_lives",  int'(lives),     2);
        checkOutput("lit_dbl_score",  int'(score),     1);
        checkOutput("lit_dbl_result", int'(result_ok), 0);

        // Timeouts.
        play_timeout(4'b0000);
        checkOutput("lit_to0_score",  int'(score),     2);
        checkOutput("lit_to0_result", int'(result_ok), 1);
        play_timeout(4'b1000);
        checkOutput("lit_to8_lives",  int'(lives),     1);
        checkOutput("lit_to8_result", int'(result_ok), 0);

        // The press lands in the same cycle as the timeout, and the press wins.
        play_press(4'b1000, 4'b1000, window(exp_score) - 3);
        checkOutput("lit_tie_result", int'(result_ok), 1);
        checkOutput("lit_tie_score",  int'(score),     3);

        // Third wrong answer ends the game.
        play_press(4'b0001, 4'b0010, 1);
        checkOutput("lit_over_lives", int'(lives),     0);
        checkOutput("lit_over_flag",  int'(game_over), 1);

        // OVER ignores further prompts and presses.
        applyStimulus(1'b1, 4'b0100, 4'd0);
        tick();
        applyStimulus(1'b0, 4'hF, 4'b0100);
        repeat (5) tick();
        applyStimulus(1'b0, 4'hF, 4'd0);
        repeat (3) tick();
        checkOutput("lit_over_busy",  int'(busy),  0);
        checkOutput("lit_over_score", int'(score), 3);

        do_reset(2);
        checkOutput("lit_rst_game_over", int'(game_over), 0);

        // Reset in the middle of the answer window discards the round.
        applyStimulus(1'b1, 4'b0010, 4'd0);
        exp_busy = 1'b1;
        tick();
        repeat (5) tick();
        do_reset(2);
        repeat (20) tick();

        // A switch held through round_start keeps the round armed.
        applyStimulus(1'b0, 4'hF, 4'b0001);
        repeat (3) tick();
        applyStimulus(1'b1, 4'b0000, 4'b0001);
        exp_busy = 1'b1;
        repeat (6) tick();
        checkOutput("lit_arm_busy", int'(busy),       1);
        checkOutput("lit_arm_done", int'(round_done), 0);
        applyStimulus(1'b0, 4'hF, 4'd0);
        tick();
        tick();
        repeat (window(exp_score)) tick();
        model_judge(1'b1);
        tick();
        model_end_judge();
        checkOutput("lit_arm_score", int'(score), 1);

        // Build the score to 8, check the window length, then saturate at 99.
        do_reset(2);
        for (int i = 0; i < 8; i++) play_press(4'b0100, 4'b0100, i % 2);
        checkOutput("lit_score8", int'(score), 8);
        applyStimulus(1'b1, 4'b0000, 4'd0);
        exp_busy = 1'b1;
        tick();
        repeat (WIN_AT_8 - 1) tick();
        checkOutput("lit_win_not_yet", int'(round_done), 0);
        tick();
        model_judge(1'b1);
        checkOutput("lit_win_edge", int'(round_done), 1);
        tick();
        model_end_judge();
        for (int i = 0; i < 95; i++) begin
            if (i % 2 == 1) play_press(4'b0110, 4'b0010, 0);
            else            play_press(4'b0001, 4'b0001, 0);
        end
        checkOutput("lit_sat_score", int'(score), 99);
        checkOutput("lit_sat_lives", int'(lives), 3);

        check_en = 1'b0;
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/not_not_judge.md
NOT_NOT_JUDGE -- requirements
Module: not_not_judge

Interface
REQ-001 Parameter TICKS_PER_ROUND, default 50000000: round answer window in CLOCK_50 cycles; legal range 16 to 2^26-1.
REQ-002 Parameter START_LIVES, default 3: lives loaded at reset; legal range 1-3.
REQ-003 CLOCK_50  input  1  sole clock; all state rising-edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 round_start  input  1  one-cycle pulse; prompt is valid this cycle.
REQ-006 expected  input  4  acceptable-switch mask for the prompt, sampled on round_start.
REQ-007 player_sw  input  4  raw asynchronous player switches.
REQ-008 score  output  7  correct-answer count, binary, 0-99.
REQ-009 lives  output  2  remaining lives.
REQ-010 round_done  output  1  one-cycle pulse when a round is judged.
REQ-011 result_ok  output  1  verdict of the last judged round, held until the next judgement.
REQ-012 busy  output  1  high in ARM, WAIT and JUDGE.
REQ-013 game_over  output  1  high in OVER.

Function
REQ-014 player_sw shall pass through a 2-flop synchronizer; a press is a 0->1 transition of a synchronized bit.
REQ-015 States: IDLE, ARM, WAIT, JUDGE, OVER.
REQ-016 IDLE: round_start latches expected into mask_q and enters ARM; round_start in any other state is ignored.
REQ-017 ARM: hold until all synchronized switches read 0, then clear the timer and enter WAIT; the timer does not run in ARM.
REQ-018 WAIT: the timer increments each cycle; the first cycle with at least one press, or the timer reaching limit-1, enters JUDGE.
REQ-019 Verdict on a press: ok = exactly one bit pressed AND that bit set in mask_q; simultaneous multi-bit press = wrong.
REQ-020 Verdict on timeout: ok = (mask_q == 4'b0000).
REQ-021 A press and a timeout in the same cycle: the press wins.
REQ-022 JUDGE (one cycle): pulse round_done and update result_ok; on ok, score +1, saturating at 99; on wrong, lives -1.
REQ-023 Next state after JUDGE: OVER if lives becomes 0, else IDLE.
REQ-024 Latency: round_done asserts exactly 3 cycles after the raw player_sw edge (2 sync + 1 detect into JUDGE), absent metastability.
REQ-025 OVER is absorbing: outputs frozen, game_over=1; exit only by reset.
REQ-026 The timer shall be wide enough for TICKS_PER_ROUND and shall never wrap.

Reset
REQ-027 On resetn=0, immediately: state=IDLE, score=0, lives=START_LIVES, result_ok=0, round_done=0, busy=0, game_over=0, timer=0, mask_q=0, synchronizers=0.
REQ-028 Reset in the middle of a round shall discard the round with no round_done.
REQ-029 Reset release takes effect on the first clock edge after deassertion; no round starts before a round_start.

Configuration
REQ-030 Macro NOT_NOT_SPEEDUP_EN defined: limit = TICKS_PER_ROUND - score*(TICKS_PER_ROUND>>4), floored at TICKS_PER_ROUND>>2, computed at ARM->WAIT.
REQ-031 NOT_NOT_SPEEDUP_EN undefined: limit = TICKS_PER_ROUND always; no speedup logic is present.

Verification (TICKS_PER_ROUND=16, START_LIVES=3)
REQ-032 Correct press: expected=4'b0100, press player_sw[2] -> round_done after 3 cycles, result_ok=1, score=1, lives=3.
REQ-033 Double press: expected=4'b0011, player_sw 0000->0011 in one cycle -> result_ok=0, lives=2, score unchanged.
REQ-034 Timeouts: expected=4'b0000 with no press -> round_done 16 cycles after WAIT entry, result_ok=1; expected=4'b1000 with no press -> result_ok=0.
REQ-035 Arming and game over: switch held high through round_start -> stays in ARM, no timer; three wrong rounds -> lives=0, game_over=1, later round_start ignored.
REQ-036 Reset mid-WAIT and saturation: resetn pulse in WAIT -> all REQ-027 values, no round_done; 100 correct rounds -> score=99; with NOT_NOT_SPEEDUP_EN at score=8 -> window is 8 cycles.
